vx_lsu_mem_router: RTL and testbench
====================================

# vx_lsu_mem_router

Per-lane address router between the LSU D-cache request/response port and two memory targets: the data cache and the core-local shared memory. Each request lane is steered by address decode. Responses from both targets are buffered and merged back into a single LSU response stream. Responses carrying the same tag are coalesced into one beat. The block sits directly downstream of the LSU and upstream of the D-cache and shared-memory banks.

## Interface
Reset is asynchronous and active-low. The clock and reset ports are named `clk` and `reset`.

Parameters:
- NUM_THREADS, 4, number of lanes
- TAG_WIDTH, 8, core request tag width
- SMEM_BASE, 32'hFF00_0000, shared-memory byte base address (4-byte aligned)
- SMEM_SIZE, 16384, shared-memory size in bytes (power of two)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- core_req_valid  in  NUM_THREADS  per-lane request valid
- core_req_rw  in  NUM_THREADS  1=write
- core_req_addr  in  NUM_THREADS*30  word address
- core_req_byteen  in  NUM_THREADS*4  byte enables
- core_req_data  in  NUM_THREADS*32  write data
- core_req_tag  in  NUM_THREADS*TAG_WIDTH  tag
- core_req_ready  out  NUM_THREADS  per-lane accept
- dc_req_* / sm_req_*  out  same shapes as core_req_*  target requests
- dc_req_ready / sm_req_ready  in  NUM_THREADS  target per-lane accept
- dc_rsp_valid / sm_rsp_valid  in  NUM_THREADS  per-lane response valid
- dc_rsp_data / sm_rsp_data  in  NUM_THREADS*32  response data
- dc_rsp_tag / sm_rsp_tag  in  TAG_WIDTH  response tag
- dc_rsp_ready / sm_rsp_ready  out  1  target response accept
- core_rsp_valid  out  NUM_THREADS  merged per-lane valid
- core_rsp_data  out  NUM_THREADS*32  merged data
- core_rsp_tag  out  TAG_WIDTH  tag
- core_rsp_ready  in  1  LSU accept

## Operation
- Lane i is shared-memory when SMEM_BASE>>2 <= addr[i] < (SMEM_BASE+SMEM_SIZE)>>2. Compare at 30-bit word granularity; an upper bound that overflows 30 bits saturates to "all above base".
- Request path is combinational pass-through. dc_req_valid[i] = core_req_valid[i] & ~is_sm[i]. sm_req_valid[i] = core_req_valid[i] & is_sm[i]. core_req_ready[i] = is_sm[i] ? sm_req_ready[i] : dc_req_ready[i]. Data, address, byteen and tag fan out to both targets unchanged.
- Each response source has a one-entry buffer holding valid, mask, data and tag.
  - A source response is accepted when |rsp_valid & rsp_ready.
  - rsp_ready = ~buf_valid | buf_drained_this_cycle.
- Output arbitration. The output register is loaded when ~core_rsp_valid | core_rsp_ready.
  - Only one buffer valid: issue that buffer.
  - Both valid, tags equal: merge in one beat. valid = mask_dc | mask_sm. Lane data comes from the buffer whose mask bit is set. Masks are disjoint by construction. Both buffers drain.
  - Both valid, tags differ: round-robin. The pointer starts at DC after reset and toggles only on a contested grant. The loser holds.
- core_rsp_* is registered. Output data for lanes whose valid bit is clear is don't-care.

## Timing
- Request path: zero latency.
- Response path: source response accepted at cycle N, core_rsp_valid at N+1 if the output is free. Sustained throughput is one beat per cycle per source with no bubbles.
- Reset asserted at any time clears buffer valids, the output valid and the RR pointer (=DC) immediately. Reset outputs:
  - core_rsp_valid = 0
  - dc_rsp_ready / sm_rsp_ready = 1
  - request outputs follow inputs
- Backpressure: while core_rsp_valid & ~core_rsp_ready, the output holds stable, buffers hold, and full buffers deassert their rsp_ready.

## Structure
- Shared package vx_lsu_mem_pkg holds:
  - rsp_buf_t struct (valid, mask, data, tag)
  - SMEM address-decode function
  - a source enum {SRC_DC, SRC_SM}
- One natural sub-module: vx_rsp_skid_buf (one-entry response buffer with ready generation), instantiated twice.

## Test plan
- Lanes at addr 0x3FC00000 (SM) and 0x00000010 (DC), both targets ready -> sm_req_valid=0001 and dc_req_valid=0010; core_req_ready mirrors each target's ready.
- DC response tag 5 mask 0011 and SM response tag 5 mask 1100 in the same cycle -> one beat next cycle: valid=1111, tag 5, lanes 2–3 carry SM data.
- DC tag 3 and SM tag 7 simultaneously, repeated 4 cycles -> grants alternate DC, SM, DC, SM.
- core_rsp_ready=0 for 3 cycles while both sources push -> output stable; both rsp_ready drop after one accept each; no data lost after release.
- reset asserted mid-burst with buffers full -> core_rsp_valid=0 and both rsp_ready=1 immediately, no clock edge required.
- addr exactly (SMEM_BASE+SMEM_SIZE)>>2 -> routed to DC; addr (SMEM_BASE>>2) -> routed to SM.

Source files
------------

// File: rtl/vx_lsu_mem_pkg.sv
// vx_lsu_mem_pkg: shared types and shared-memory address decode for the LSU memory router
package vx_lsu_mem_pkg;

    localparam int LSU_NUM_THREADS = 4;
    localparam int LSU_TAG_WIDTH   = 8;

    typedef enum logic {SRC_DC = 1'b0, SRC_SM = 1'b1} src_e;

    typedef struct packed {
        logic                           valid;
        logic [LSU_NUM_THREADS-1:0]     mask;
        logic [LSU_NUM_THREADS*32-1:0]  data;
        logic [LSU_TAG_WIDTH-1:0]       tag;
    } rsp_buf_t;

    // Bounds are formed in 33 bits so an upper bound past the 30-bit word
    // space simply leaves every address above the base inside the window.
    function automatic logic smem_hit(input logic [29:0] addr, input logic [31:0] base,
                                      input logic [31:0] size);
        logic [32:0] lo;
        logic [32:0] hi;
        lo = {1'b0, base} >> 2;
        hi = ({1'b0, base} + {1'b0, size}) >> 2;
        return ({3'b0, addr} >= lo) && ({3'b0, addr} < hi);
    endfunction

endpackage

// File: rtl/vx_rsp_skid_buf.sv
// vx_rsp_skid_buf: one-entry response buffer for one memory target
//   clk, reset       clock, async active-low reset
//   in_valid/data/tag target response (per-lane valid, lane data, shared tag)
//   in_ready         target response accept
//   drain            arbiter consumes the held entry this cycle
//   buf_q            held entry (valid, mask, data, tag)
module vx_rsp_skid_buf
    import vx_lsu_mem_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic [LSU_NUM_THREADS-1:0]    in_valid,
    input  logic [LSU_NUM_THREADS*32-1:0] in_data,
    input  logic [LSU_TAG_WIDTH-1:0]      in_tag,
    output logic                          in_ready,
    input  logic                          drain,
    output rsp_buf_t                      buf_q
);

    rsp_buf_t buf_d;

    always_comb begin
        in_ready = ~buf_q.valid | drain;
        buf_d = buf_q;
        if (drain) buf_d.valid = 1'b0;
        if (|in_valid && in_ready) buf_d = '{valid: 1'b1, mask: in_valid, data: in_data, tag: in_tag};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) buf_q <= '0;
        else        buf_q <= buf_d;
    end

endmodule

// File: rtl/vx_lsu_mem_router.sv
// vx_lsu_mem_router: steers LSU lanes to D-cache or shared memory and merges responses
//   clk, reset         clock, async active-low reset
//   core_req_*         LSU per-lane requests in, core_req_ready per-lane accept out
//   dc_req_* / sm_req_* per-lane requests to D-cache / shared memory
//   dc_rsp_* / sm_rsp_* target responses in, *_rsp_ready accept out
//   core_rsp_*         registered merged response to the LSU
module vx_lsu_mem_router
    import vx_lsu_mem_pkg::*;
#(
    parameter int          NUM_THREADS = LSU_NUM_THREADS,
    parameter int          TAG_WIDTH   = LSU_TAG_WIDTH,
    parameter logic [31:0] SMEM_BASE   = 32'hFF00_0000,
    parameter int          SMEM_SIZE   = 16384
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_THREADS-1:0]         core_req_valid,
    input  logic [NUM_THREADS-1:0]         core_req_rw,
    input  logic [NUM_THREADS*30-1:0]      core_req_addr,
    input  logic [NUM_THREADS*4-1:0]       core_req_byteen,
    input  logic [NUM_THREADS*32-1:0]      core_req_data,
    input  logic [NUM_THREADS*TAG_WIDTH-1:0] core_req_tag,
    output logic [NUM_THREADS-1:0]         core_req_ready,
    output logic [NUM_THREADS-1:0]         dc_req_valid,
    output logic [NUM_THREADS-1:0]         dc_req_rw,
    output logic [NUM_THREADS*30-1:0]      dc_req_addr,
    output logic [NUM_THREADS*4-1:0]       dc_req_byteen,
    output logic [NUM_THREADS*32-1:0]      dc_req_data,
    output logic [NUM_THREADS*TAG_WIDTH-1:0] dc_req_tag,
    input  logic [NUM_THREADS-1:0]         dc_req_ready,
    output logic [NUM_THREADS-1:0]         sm_req_valid,
    output logic [NUM_THREADS-1:0]         sm_req_rw,
    output logic [NUM_THREADS*30-1:0]      sm_req_addr,
    output logic [NUM_THREADS*4-1:0]       sm_req_byteen,
    output logic [NUM_THREADS*32-1:0]      sm_req_data,
    output logic [NUM_THREADS*TAG_WIDTH-1:0] sm_req_tag,
    input  logic [NUM_THREADS-1:0]         sm_req_ready,
    input  logic [NUM_THREADS-1:0]         dc_rsp_valid,
    input  logic [NUM_THREADS*32-1:0]      dc_rsp_data,
    input  logic [TAG_WIDTH-1:0]           dc_rsp_tag,
    output logic                           dc_rsp_ready,
    input  logic [NUM_THREADS-1:0]         sm_rsp_valid,
    input  logic [NUM_THREADS*32-1:0]      sm_rsp_data,
    input  logic [TAG_WIDTH-1:0]           sm_rsp_tag,
    output logic                           sm_rsp_ready,
    output logic [NUM_THREADS-1:0]         core_rsp_valid,
    output logic [NUM_THREADS*32-1:0]      core_rsp_data,
    output logic [TAG_WIDTH-1:0]           core_rsp_tag,
    input  logic                           core_rsp_ready
);

    logic [NUM_THREADS-1:0]    is_sm;
    rsp_buf_t                  dc_buf;
    rsp_buf_t                  sm_buf;
    logic                      dc_drain;
    logic                      sm_drain;
    logic                      load;
    logic                      contest;
    src_e                      rr_q, rr_d;
    logic [NUM_THREADS-1:0]    out_valid_q, out_valid_d;
    logic [NUM_THREADS*32-1:0] out_data_q, out_data_d;
    logic [TAG_WIDTH-1:0]      out_tag_q, out_tag_d;

    for (genvar i = 0; i < NUM_THREADS; i++) begin : g_dec
        assign is_sm[i] = smem_hit(core_req_addr[i*30 +: 30], SMEM_BASE, 32'(SMEM_SIZE));
    end

    assign dc_req_valid   = core_req_valid & ~is_sm;
    assign sm_req_valid   = core_req_valid & is_sm;
    assign core_req_ready = (is_sm & sm_req_ready) | (~is_sm & dc_req_ready);
    assign dc_req_rw      = core_req_rw;
    assign dc_req_addr    = core_req_addr;
    assign dc_req_byteen  = core_req_byteen;
    assign dc_req_data    = core_req_data;
    assign dc_req_tag     = core_req_tag;
    assign sm_req_rw      = core_req_rw;
    assign sm_req_addr    = core_req_addr;
    assign sm_req_byteen  = core_req_byteen;
    assign sm_req_data    = core_req_data;
    assign sm_req_tag     = core_req_tag;

    vx_rsp_skid_buf u_dc_buf (
        .clk      (clk),
        .reset    (reset),
        .in_valid (dc_rsp_valid),
        .in_data  (dc_rsp_data),
        .in_tag   (dc_rsp_tag),
        .in_ready (dc_rsp_ready),
        .drain    (dc_drain),
        .buf_q    (dc_buf)
    );

    vx_rsp_skid_buf u_sm_buf (
        .clk      (clk),
        .reset    (reset),
        .in_valid (sm_rsp_valid),
        .in_data  (sm_rsp_data),
        .in_tag   (sm_rsp_tag),
        .in_ready (sm_rsp_ready),
        .drain    (sm_drain),
        .buf_q    (sm_buf)
    );

    // Equal tags coalesce into one beat; only differing tags contend for the RR pointer.
    always_comb begin
        load        = ~|out_valid_q | core_rsp_ready;
        contest     = dc_buf.valid & sm_buf.valid & (dc_buf.tag != sm_buf.tag);
        dc_drain    = load & dc_buf.valid & (~contest | (rr_q == SRC_DC));
        sm_drain    = load & sm_buf.valid & (~contest | (rr_q == SRC_SM));
        rr_d        = (load & contest) ? ((rr_q == SRC_DC) ? SRC_SM : SRC_DC) : rr_q;
        out_valid_d = load ? ((dc_drain ? dc_buf.mask : '0) | (sm_drain ? sm_buf.mask : '0)) : out_valid_q;
        out_tag_d   = load ? (dc_drain ? dc_buf.tag : sm_buf.tag) : out_tag_q;
        out_data_d  = out_data_q;
        for (int i = 0; i < NUM_THREADS; i++)
            if (load) out_data_d[i*32 +: 32] = (sm_drain & sm_buf.mask[i]) ? sm_buf.data[i*32 +: 32]
                                                                        : dc_buf.data[i*32 +: 32];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_q        <= SRC_DC;
            out_valid_q <= '0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
        end else begin
            rr_q        <= rr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
        end
    end

    assign core_rsp_valid = out_valid_q;
    assign core_rsp_data  = out_data_q;
    assign core_rsp_tag   = out_tag_q;

endmodule

// File: tb/tb_vx_lsu_mem_router.sv
// tb_vx_lsu_mem_router: randomized self-checking bench with a transaction-level reference model
module tb_vx_lsu_mem_router;

    localparam longint unsigned SMEM_BASE = 64'hFF00_0000;
    localparam longint unsigned SMEM_SIZE = 16384;
    localparam logic [29:0] LO = 30'((SMEM_BASE) / 4);
    localparam logic [29:0] HI = 30'((SMEM_BASE + SMEM_SIZE) / 4);

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   core_req_valid, core_req_rw, core_req_ready;
    logic [119:0] core_req_addr;
    logic [15:0]  core_req_byteen;
    logic [127:0] core_req_data;
    logic [31:0]  core_req_tag;
    logic [3:0]   dc_req_valid, dc_req_rw, dc_req_ready;
    logic [119:0] dc_req_addr;
    logic [15:0]  dc_req_byteen;
    logic [127:0] dc_req_data;
    logic [31:0]  dc_req_tag;
    logic [3:0]   sm_req_valid, sm_req_rw, sm_req_ready;
    logic [119:0] sm_req_addr;
    logic [15:0]  sm_req_byteen;
    logic [127:0] sm_req_data;
    logic [31:0]  sm_req_tag;
    logic [3:0]   dc_rsp_valid, sm_rsp_valid, core_rsp_valid;
    logic [127:0] dc_rsp_data, sm_rsp_data, core_rsp_data;
    logic [7:0]   dc_rsp_tag, sm_rsp_tag, core_rsp_tag;
    logic         dc_rsp_ready, sm_rsp_ready, core_rsp_ready;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: one pending response per source (0=DC, 1=SM), the LSU-side beat,
    // and which source wins the next contest (0=DC, 1=SM).
    logic         pv[2];
    logic [3:0]   pm[2];
    logic [127:0] pd[2];
    logic [7:0]   pt[2];
    logic [3:0]   ov;
    logic [127:0] od;
    logic [7:0]   ot;
    logic         rr;

    vx_lsu_mem_router dut (
        .clk(clk), .reset(reset),
        .core_req_valid(core_req_valid), .core_req_rw(core_req_rw), .core_req_addr(core_req_addr),
        .core_req_byteen(core_req_byteen), .core_req_data(core_req_data), .core_req_tag(core_req_tag),
        .core_req_ready(core_req_ready),
        .dc_req_valid(dc_req_valid), .dc_req_rw(dc_req_rw), .dc_req_addr(dc_req_addr),
        .dc_req_byteen(dc_req_byteen), .dc_req_data(dc_req_data), .dc_req_tag(dc_req_tag),
        .dc_req_ready(dc_req_ready),
        .sm_req_valid(sm_req_valid), .sm_req_rw(sm_req_rw), .sm_req_addr(sm_req_addr),
        .sm_req_byteen(sm_req_byteen), .sm_req_data(sm_req_data), .sm_req_tag(sm_req_tag),
        .sm_req_ready(sm_req_ready),
        .dc_rsp_valid(dc_rsp_valid), .dc_rsp_data(dc_rsp_data), .dc_rsp_tag(dc_rsp_tag),
        .dc_rsp_ready(dc_rsp_ready),
        .sm_rsp_valid(sm_rsp_valid), .sm_rsp_data(sm_rsp_data), .sm_rsp_tag(sm_rsp_tag),
        .sm_rsp_ready(sm_rsp_ready),
        .core_rsp_valid(core_rsp_valid), .core_rsp_data(core_rsp_data), .core_rsp_tag(core_rsp_tag),
        .core_rsp_ready(core_rsp_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic is_smem(input logic [29:0] a);
        return (64'(a) >= SMEM_BASE / 4) && (64'(a) < (SMEM_BASE + SMEM_SIZE) / 4);
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < 2; s++) pv[s] = 1'b0;
        ov = 4'h0;
        rr = 1'b0;
    endfunction

    task automatic set_rsp(input int s, input logic [3:0] mask, input logic [7:0] tag);
        logic [127:0] d;
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        if (s == 0) begin dc_rsp_valid = mask; dc_rsp_tag = tag; dc_rsp_data = d; end
        else        begin sm_rsp_valid = mask; sm_rsp_tag = tag; sm_rsp_data = d; end
    endtask

    task automatic rand_req();
        core_req_valid  = 4'($urandom());
        core_req_rw     = 4'($urandom());
        core_req_byteen = 16'($urandom());
        core_req_data   = {$urandom(), $urandom(), $urandom(), $urandom()};
        core_req_tag    = $urandom();
        dc_req_ready    = 4'($urandom());
        sm_req_ready    = 4'($urandom());
        for (int l = 0; l < 4; l++)
            case ($urandom_range(0, 5))
                0: core_req_addr[l*30 +: 30] = LO;
                1: core_req_addr[l*30 +: 30] = LO - 30'd1;
                2: core_req_addr[l*30 +: 30] = HI;
                3: core_req_addr[l*30 +: 30] = HI - 30'd1;
                4: core_req_addr[l*30 +: 30] = LO + 30'($urandom_range(0, 4095));
                default: core_req_addr[l*30 +: 30] = 30'($urandom());
            endcase
    endtask

    // Checks every observable against the model, then advances one clock.
    task automatic tick();
        logic [3:0]   ism;
        logic [3:0]   vin[2];
        logic [127:0] din[2];
        logic [7:0]   tin[2];
        logic [127:0] lm;
        logic [1:0]   g, rdy;
        logic         ld;
        #1;
        for (int l = 0; l < 4; l++) ism[l] = is_smem(core_req_addr[l*30 +: 30]);
        check("dc_req_valid", dc_req_valid, core_req_valid & ~ism);
        check("sm_req_valid", sm_req_valid, core_req_valid & ism);
        for (int l = 0; l < 4; l++)
            check("core_req_ready", core_req_ready[l], ism[l] ? sm_req_ready[l] : dc_req_ready[l]);
        check("dc_req_addr", dc_req_addr, core_req_addr);
        check("sm_req_addr", sm_req_addr, core_req_addr);
        check("dc_req_data", dc_req_data, core_req_data);
        check("sm_req_data", sm_req_data, core_req_data);
        check("dc_req_misc", {dc_req_rw, dc_req_byteen, dc_req_tag}, {core_req_rw, core_req_byteen, core_req_tag});
        check("sm_req_misc", {sm_req_rw, sm_req_byteen, sm_req_tag}, {core_req_rw, core_req_byteen, core_req_tag});
        ld = (ov == 4'h0) || core_rsp_ready;
        g = 2'b00;
        if (ld && pv[0] && pv[1]) g = (pt[0] == pt[1]) ? 2'b11 : (rr ? 2'b10 : 2'b01);
        else if (ld)              g = {pv[1], pv[0]};
        for (int s = 0; s < 2; s++) rdy[s] = !pv[s] || g[s];
        check("dc_rsp_ready", dc_rsp_ready, rdy[0]);
        check("sm_rsp_ready", sm_rsp_ready, rdy[1]);
        check("core_rsp_valid", core_rsp_valid, ov);
        if (ov != 4'h0) begin
            for (int l = 0; l < 4; l++) lm[l*32 +: 32] = {32{ov[l]}};
            check("core_rsp_tag", core_rsp_tag, ot);
            check("core_rsp_data", core_rsp_data & lm, od & lm);
        end
        @(posedge clk);
        vin[0] = dc_rsp_valid; din[0] = dc_rsp_data; tin[0] = dc_rsp_tag;
        vin[1] = sm_rsp_valid; din[1] = sm_rsp_data; tin[1] = sm_rsp_tag;
        if (!reset) model_reset();
        else begin
            if (ld) begin
                ov = (g[0] ? pm[0] : 4'h0) | (g[1] ? pm[1] : 4'h0);
                for (int l = 0; l < 4; l++)
                    od[l*32 +: 32] = (g[1] && pm[1][l]) ? pd[1][l*32 +: 32] : pd[0][l*32 +: 32];
                ot = g[0] ? pt[0] : pt[1];
                if (pv[0] && pv[1] && pt[0] != pt[1]) rr = !rr;
            end
            for (int s = 0; s < 2; s++) begin
                if (g[s]) pv[s] = 1'b0;
                if (vin[s] != 4'h0 && rdy[s]) begin
                    pv[s] = 1'b1; pm[s] = vin[s]; pd[s] = din[s]; pt[s] = tin[s];
                end
            end
        end
        #1;
    endtask

    initial begin
        logic [127:0] sm_saved, dc_saved, snap_d;
        logic [3:0]   snap_v;
        logic [7:0]   snap_t;
        logic [7:0]   tq[$];
        int           rr_exp[5] = '{3, 7, 3, 7, 3};
        int           beats;
        reset = 1'b0;
        core_rsp_ready = 1'b1;
        rand_req();
        set_rsp(0, 4'h0, 8'h0);
        set_rsp(1, 4'h0, 8'h0);
        model_reset();
        check("rst_core_rsp_valid", core_rsp_valid, 4'h0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // address decode and request fan-out
        core_req_valid = 4'b0011;
        core_req_addr  = {30'h0, 30'h0, 30'h0000_0010, 30'h3FC0_0000};
        dc_req_ready   = 4'hF;
        sm_req_ready   = 4'hF;
        #1;
        check("addr_sm_valid", sm_req_valid, 4'b0001);
        check("addr_dc_valid", dc_req_valid, 4'b0010);
        check("addr_req_ready", core_req_ready, 4'hF);
        sm_req_ready = 4'h0;
        #1;
        check("addr_req_ready_sm_stall", core_req_ready, 4'b1110);
        core_req_valid = 4'hF;
        core_req_addr  = {LO - 30'd1, HI - 30'd1, HI, LO};
        sm_req_ready   = 4'hF;
        #1;
        check("bound_sm_valid", sm_req_valid, 4'b0101);
        check("bound_dc_valid", dc_req_valid, 4'b1010);
        tick();

        // same-tag responses coalesce into one beat
        set_rsp(0, 4'b0011, 8'd5);
        set_rsp(1, 4'b1100, 8'd5);
        dc_saved = dc_rsp_data;
        sm_saved = sm_rsp_data;
        tick();
        check("merge_not_early", core_rsp_valid, 4'h0);
        set_rsp(0, 4'h0, 8'h0);
        set_rsp(1, 4'h0, 8'h0);
        tick();
        check("merge_valid", core_rsp_valid, 4'hF);
        check("merge_tag", core_rsp_tag, 8'd5);
        check("merge_sm_lanes", core_rsp_data[127:64], sm_saved[127:64]);
        check("merge_dc_lanes", core_rsp_data[63:0], dc_saved[63:0]);
        tick();
        tick();

        // contested grants alternate starting from DC
        for (int c = 0; c < 8; c++) begin
            if (c < 4) begin set_rsp(0, 4'b0001, 8'd3); set_rsp(1, 4'b0100, 8'd7); end
            else begin set_rsp(0, 4'h0, 8'h0); set_rsp(1, 4'h0, 8'h0); end
            tick();
            if (core_rsp_valid != 4'h0) tq.push_back(core_rsp_tag);
        end
        check("rr_beats", 128'(tq.size()), 128'd5);
        for (int i = 0; i < tq.size() && i < 5; i++) check("rr_seq", tq[i], 8'(rr_exp[i]));

        // backpressure holds the output and fills both buffers
        core_rsp_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            set_rsp(0, 4'b0011, 8'd1);
            set_rsp(1, 4'b1000, 8'd2);
            tick();
            if (c == 1) begin
                snap_v = core_rsp_valid; snap_t = core_rsp_tag; snap_d = core_rsp_data;
                check("bp_dc_ready_low", dc_rsp_ready, 1'b0);
                check("bp_sm_ready_low", sm_rsp_ready, 1'b0);
            end
            if (c >= 2) begin
                check("bp_hold_valid", core_rsp_valid, snap_v);
                check("bp_hold_tag", core_rsp_tag, snap_t);
                check("bp_hold_data", core_rsp_data, snap_d);
            end
        end
        core_rsp_ready = 1'b1;
        set_rsp(0, 4'h0, 8'h0);
        set_rsp(1, 4'h0, 8'h0);
        beats = 1;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (core_rsp_valid != 4'h0) beats++;
        end
        check("bp_drain_beats", 128'(beats), 128'd3);

        // asynchronous reset with both buffers and the output full
        core_rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            set_rsp(0, 4'b0001, 8'd9);
            set_rsp(1, 4'b0010, 8'd10);
            tick();
        end
        check("pre_rst_dc_full", dc_rsp_ready, 1'b0);
        reset = 1'b0;
        #2;
        check("rst_async_valid", core_rsp_valid, 4'h0);
        check("rst_async_dc_ready", dc_rsp_ready, 1'b1);
        check("rst_async_sm_ready", sm_rsp_ready, 1'b1);
        model_reset();
        set_rsp(0, 4'h0, 8'h0);
        set_rsp(1, 4'h0, 8'h0);
        tick();
        reset = 1'b1;
        tick();

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            rand_req();
            core_rsp_ready = ($urandom_range(0, 9) < 7);
            if (c < 300) begin
                set_rsp(0, ($urandom_range(0, 9) < 6) ? {2'b00, 2'($urandom_range(1, 3))} : 4'h0,
                        8'($urandom_range(0, 3)));
                set_rsp(1, ($urandom_range(0, 9) < 6) ? {2'($urandom_range(1, 3)), 2'b00} : 4'h0,
                        8'($urandom_range(0, 3)));
            end else begin
                set_rsp(0, ($urandom_range(0, 9) < 6) ? 4'($urandom_range(1, 15)) : 4'h0,
                        8'($urandom_range(0, 7)));
                set_rsp(1, ($urandom_range(0, 9) < 6) ? 4'($urandom_range(1, 15)) : 4'h0,
                        8'($urandom_range(8, 15)));
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
